// File: rtl/hub75_pkg.sv
// Shared types and defaults for the HUB75 receive path: pixel triples,
// line geometry, latch error codes and the line-streaming FSM states.
package hub75_pkg;

  localparam int unsigned COLUMNS_DEF = 32;
  localparam int unsigned ROWS_DEF    = 8;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  // Bit order matches the wire bundle {r1,g1,b1,r0,g0,b0}.
  typedef struct packed {
    rgb_t half1;
    rgb_t half0;
  } pixel_pair_t;

  // Latch verdicts; when several apply, the first match in classify_latch wins.
  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_OVERRUN = 2'd1,
    ERR_SHORT   = 2'd2,
    ERR_DROP    = 2'd3
  } err_code_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  function automatic err_code_e classify_latch(input logic ovf, input logic full,
                                               input logic busy);
    if (ovf)   return ERR_OVERRUN;
    if (!full) return ERR_SHORT;
    if (busy)  return ERR_DROP;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/hub75_input_sampler.sv
// Registers the panel-side HUB75 signals once and turns oclk/lat into
// one-cycle rise strobes, with data and address delayed to stay aligned.
module hub75_input_sampler #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              oe_i,
  input  logic              lat_i,
  input  logic              oclk_i,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              oe_o,
  output logic              oclk_rise_o,
  output logic              lat_rise_o
);

  logic [DATA_W-1:0] data_s1_q, data_s2_q;
  logic [ADDR_W-1:0] addr_s1_q, addr_s2_q;
  logic              oe_s1_q, oe_s2_q;
  logic              lat_s1_q, lat_s2_q;
  logic              oclk_s1_q, oclk_s2_q;
  logic              lat_rise_q, oclk_rise_q;
  logic              lat_rise_d, oclk_rise_d;

  assign lat_rise_d  = lat_s1_q & ~lat_s2_q;
  assign oclk_rise_d = oclk_s1_q & ~oclk_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_s1_q   <= '0;
      data_s2_q   <= '0;
      addr_s1_q   <= '0;
      addr_s2_q   <= '0;
      // Dark panel out of reset, so the on-time counter does not tick on pipeline fill.
      oe_s1_q     <= 1'b1;
      oe_s2_q     <= 1'b1;
      lat_s1_q    <= 1'b0;
      lat_s2_q    <= 1'b0;
      oclk_s1_q   <= 1'b0;
      oclk_s2_q   <= 1'b0;
      lat_rise_q  <= 1'b0;
      oclk_rise_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every stage reads the previous cycle's value.
      data_s1_q   <= data_i;
      addr_s1_q   <= addr_i;
      oe_s1_q     <= oe_i;
      lat_s1_q    <= lat_i;
      oclk_s1_q   <= oclk_i;
      data_s2_q   <= data_s1_q;
      addr_s2_q   <= addr_s1_q;
      oe_s2_q     <= oe_s1_q;
      lat_s2_q    <= lat_s1_q;
      oclk_s2_q   <= oclk_s1_q;
      lat_rise_q  <= lat_rise_d;
      oclk_rise_q <= oclk_rise_d;
    end
  end

  assign data_o      = data_s2_q;
  assign addr_o      = addr_s2_q;
  assign oe_o        = oe_s2_q;
  assign oclk_rise_o = oclk_rise_q;
  assign lat_rise_o  = lat_rise_q;

endmodule

// File: rtl/hub75_receiver.sv
// HUB75 loopback receiver: rebuilds each latched line into a per-column
// pixel stream and flags short, overrun and dropped lines plus per-row on-time.
module hub75_receiver
  import hub75_pkg::*;
#(
  parameter int unsigned ROWS    = ROWS_DEF,
  parameter int unsigned COLUMNS = COLUMNS_DEF,
  localparam int unsigned ROW_W  = $clog2(ROWS),
  localparam int unsigned X_W    = $clog2(COLUMNS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0,
  input  logic             g0,
  input  logic             b0,
  input  logic             r1,
  input  logic             g1,
  input  logic             b1,
  input  logic             a0,
  input  logic             a1,
  input  logic             a2,
  input  logic             oe,
  input  logic             lat,
  input  logic             oclk,
  output logic             px_valid,
  input  logic             px_ready,
  output logic [X_W-1:0]   px_x,
  output logic [ROW_W-1:0] px_row,
  output logic [2:0]       px_rgb0,
  output logic [2:0]       px_rgb1,
  output logic             px_last,
  output logic [15:0]      on_cycles,
  output logic             err_short,
  output logic             err_overrun,
  output logic             err_drop
);

  localparam int unsigned CNT_W = $clog2(COLUMNS + 1);

  pixel_pair_t pix_s;
  logic [2:0]  addr_s;
  logic        oe_s, oclk_rise, lat_rise;

  hub75_input_sampler #(
    .DATA_W (6),
    .ADDR_W (3)
  ) u_sampler (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_i      ({r1, g1, b1, r0, g0, b0}),
    .addr_i      ({a2, a1, a0}),
    .oe_i        (oe),
    .lat_i       (lat),
    .oclk_i      (oclk),
    .data_o      (pix_s),
    .addr_o      (addr_s),
    .oe_o        (oe_s),
    .oclk_rise_o (oclk_rise),
    .lat_rise_o  (lat_rise)
  );

  pixel_pair_t      shbuf_q   [COLUMNS];
  pixel_pair_t      shbuf_d   [COLUMNS];
  pixel_pair_t      linebuf_q [COLUMNS];
  logic [CNT_W-1:0] shcnt_q, shcnt_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      oecnt_q, oecnt_d;
  logic [15:0]      on_cycles_q;
  logic [ROW_W-1:0] px_row_q;
  logic             err_short_q, err_overrun_q, err_drop_q;
  logic             line_full, accept;
  err_code_e        err_code;
  state_e           state_q, state_d;
  logic [X_W-1:0]   x_q, x_d;

  // Shift and latch resolve in one pass so a same-cycle latch sees the post-shift count.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    shbuf_d   = shbuf_q;
    shcnt_d   = shcnt_q;
    ovf_d     = ovf_q;
    oecnt_d   = oecnt_q;
    line_full = 1'b0;
    err_code  = ERR_NONE;
    accept    = 1'b0;

    if (oclk_rise) begin
      if (shcnt_q == CNT_W'(COLUMNS)) begin
        ovf_d = 1'b1;
      end else begin
        shbuf_d[X_W'(COLUMNS - 1) - shcnt_q[X_W-1:0]] = pix_s;
        shcnt_d = shcnt_q + CNT_W'(1);
      end
    end

    if (!oe_s && oecnt_q != 16'hFFFF) oecnt_d = oecnt_q + 16'd1;

    if (lat_rise) begin
      line_full = (shcnt_d == CNT_W'(COLUMNS));
      err_code  = classify_latch(ovf_d, line_full, state_q == ST_SEND);
      accept    = (err_code == ERR_NONE);
      shcnt_d   = '0;
      ovf_d     = 1'b0;
      oecnt_d   = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SEND;
          x_d     = '0;
        end
      end
      ST_SEND: begin
        if (px_ready) begin
          if (x_q == X_W'(COLUMNS - 1)) state_d = ST_IDLE;
          x_d = x_q + X_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: buffers are reset because the beat data outputs read them and must be 0 in reset.
      shbuf_q       <= '{default: '0};
      linebuf_q     <= '{default: '0};
      shcnt_q       <= '0;
      ovf_q         <= 1'b0;
      oecnt_q       <= '0;
      on_cycles_q   <= '0;
      px_row_q      <= '0;
      err_short_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      err_drop_q    <= 1'b0;
      state_q       <= ST_IDLE;
      x_q           <= '0;
    end else begin
      shbuf_q       <= shbuf_d;
      shcnt_q       <= shcnt_d;
      ovf_q         <= ovf_d;
      oecnt_q       <= oecnt_d;
      err_short_q   <= (err_code == ERR_SHORT);
      err_overrun_q <= (err_code == ERR_OVERRUN);
      err_drop_q    <= (err_code == ERR_DROP);
      state_q       <= state_d;
      x_q           <= x_d;
      if (lat_rise) on_cycles_q <= oecnt_q;
      if (accept) begin
        linebuf_q <= shbuf_d;
        px_row_q  <= addr_s[ROW_W-1:0];
      end
    end
  end

  assign px_valid    = (state_q == ST_SEND);
  assign px_x        = x_q;
  assign px_row      = px_row_q;
  assign px_rgb0     = linebuf_q[x_q].half0;
  assign px_rgb1     = linebuf_q[x_q].half1;
  assign px_last     = px_valid && (x_q == X_W'(COLUMNS - 1));
  assign on_cycles   = on_cycles_q;
  assign err_short   = err_short_q;
  assign err_overrun = err_overrun_q;
  assign err_drop    = err_drop_q;

endmodule

// File: tb/tb_hub75_receiver.sv
// Directed bench for hub75_receiver: a table of line scenarios plus
// hand-written backpressure/drop and reset-mid-stream sequences.
module tb_hub75_receiver;

  localparam int COLS = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       r0, g0, b0, r1, g1, b1, a0, a1, a2;
  logic       oe, lat, oclk, px_ready;
  logic       px_valid, px_last;
  logic [4:0] px_x;
  logic [2:0] px_row, px_rgb0, px_rgb1;
  logic [15:0] on_cycles;
  logic       err_short, err_overrun, err_drop;

  always #5 clk = ~clk;

  hub75_receiver #(.ROWS(8), .COLUMNS(COLS)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .a0(a0), .a1(a1), .a2(a2), .oe(oe), .lat(lat), .oclk(oclk),
    .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_row(px_row),
    .px_rgb0(px_rgb0), .px_rgb1(px_rgb1), .px_last(px_last), .on_cycles(on_cycles),
    .err_short(err_short), .err_overrun(err_overrun), .err_drop(err_drop)
  );

  typedef struct packed {
    logic [4:0] x;
    logic [2:0] row;
    logic [2:0] rgb0;
    logic [2:0] rgb1;
    logic       last;
  } beat_t;

  typedef struct {
    string      name;
    int         n;        // oclk pulses
    bit         sim;      // last pulse coincides with lat
    logic [2:0] row;
    int         off;      // pattern offset: pulse i carries rgb0 = (i+off)%8
    int         oe_n;     // oe low cycles before lat
    logic [2:0] exp_err;  // {short, overrun, drop}
  } line_t;

  int    n_tests = 0, n_fail = 0;
  int    n_short = 0, n_ovr = 0, n_drop = 0;
  beat_t beats[$];
  beat_t mon_b;
  line_t tbl[6];
  line_t post_rst;

  always @(negedge clk) begin
    if (rst_n) begin
      if (err_short)   n_short++;
      if (err_overrun) n_ovr++;
      if (err_drop)    n_drop++;
      if (px_valid && px_ready) begin
        mon_b.x = px_x; mon_b.row = px_row; mon_b.rgb0 = px_rgb0;
        mon_b.rgb1 = px_rgb1; mon_b.last = px_last;
        beats.push_back(mon_b);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_rgb0(input int x, input int off);
    return 3'((COLS - 1 - x + off) % 8);
  endfunction

  task automatic shift_pulse(input int i, input int off, input bit with_lat, input logic [2:0] row);
    logic [2:0] c;
    c = 3'((i + off) % 8);
    {r0, g0, b0} = c;
    {r1, g1, b1} = 3'd7 - c;
    oclk = 1'b1;
    if (with_lat) begin
      {a2, a1, a0} = row;
      lat = 1'b1;
    end
    tick();
    oclk = 1'b0;
    lat  = 1'b0;
    tick();
  endtask

  task automatic lat_pulse(input logic [2:0] row);
    {a2, a1, a0} = row;
    lat = 1'b1;
    tick();
    lat = 1'b0;
    tick();
  endtask

  task automatic wait_x(input logic [4:0] target, input int budget);
    int k = 0;
    while (!(px_valid && px_x == target) && k < budget) begin
      tick();
      k++;
    end
    check($sformatf("reach x=%0d", target), 64'(px_valid && px_x == target), 64'd1);
  endtask

  task automatic check_beats(input string tag, input logic [2:0] row, input int off, input int n_exp);
    beat_t e;
    check($sformatf("%s beat count", tag), 64'(beats.size()), 64'(n_exp));
    foreach (beats[j]) begin
      if (j < COLS) begin
        e.x = 5'(j); e.row = row; e.rgb0 = exp_rgb0(j, off);
        e.rgb1 = 3'd7 - e.rgb0; e.last = (j == COLS - 1);
        check($sformatf("%s beat %0d", tag, j), 64'(beats[j]), 64'(e));
      end
    end
  endtask

  task automatic run_line(input line_t v);
    int s0, o0, d0;
    beats.delete();
    s0 = n_short; o0 = n_ovr; d0 = n_drop;
    px_ready = 1'b1;
    if (v.oe_n > 0) begin
      oe = 1'b0;
      repeat (v.oe_n) tick();
      oe = 1'b1;
      tick();
    end
    for (int i = 0; i < v.n; i++) shift_pulse(i, v.off, v.sim && (i == v.n - 1), v.row);
    if (!v.sim) lat_pulse(v.row);
    tick();
    check($sformatf("%s err", v.name), 64'({err_short, err_overrun, err_drop}), 64'(v.exp_err));
    check($sformatf("%s on_cycles", v.name), 64'(on_cycles), 64'(v.oe_n));
    check($sformatf("%s valid", v.name), 64'(px_valid), 64'(v.exp_err == 3'b000));
    repeat (COLS + 8) tick();
    check($sformatf("%s pulses", v.name), 64'((n_short - s0) + (n_ovr - o0) + (n_drop - d0)),
          64'(v.exp_err != 3'b000));
    check_beats(v.name, v.row, v.off, (v.exp_err == 3'b000) ? COLS : 0);
  endtask

  initial begin
    int d0;
    tbl[0] = '{name: "full",      n: 32, sim: 1'b0, row: 3'd5, off: 0, oe_n: 100, exp_err: 3'b000};
    tbl[1] = '{name: "short31",   n: 31, sim: 1'b0, row: 3'd2, off: 1, oe_n: 0,   exp_err: 3'b100};
    tbl[2] = '{name: "recover",   n: 32, sim: 1'b0, row: 3'd3, off: 2, oe_n: 7,   exp_err: 3'b000};
    tbl[3] = '{name: "overrun33", n: 33, sim: 1'b0, row: 3'd1, off: 3, oe_n: 0,   exp_err: 3'b010};
    tbl[4] = '{name: "simul",     n: 32, sim: 1'b1, row: 3'd6, off: 4, oe_n: 0,   exp_err: 3'b000};
    tbl[5] = '{name: "empty",     n: 0,  sim: 1'b0, row: 3'd0, off: 0, oe_n: 0,   exp_err: 3'b100};
    post_rst = '{name: "post_rst", n: 32, sim: 1'b0, row: 3'd5, off: 0, oe_n: 3,  exp_err: 3'b000};

    rst_n = 1'b0;
    {r0, g0, b0, r1, g1, b1, a0, a1, a2} = '0;
    oe = 1'b1; lat = 1'b0; oclk = 1'b0; px_ready = 1'b1;
    repeat (3) tick();
    check("reset outputs", 64'({px_valid, px_x, px_row, px_rgb0, px_rgb1, px_last, on_cycles,
                                err_short, err_overrun, err_drop}), 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int t = 0; t < 6; t++) run_line(tbl[t]);

    // Backpressure at x=4, then a second full line latched while still sending.
    beats.delete();
    d0 = n_drop;
    px_ready = 1'b1;
    for (int i = 0; i < COLS; i++) shift_pulse(i, 6, 1'b0, 3'd0);
    lat_pulse(3'd4);
    tick();
    check("bp first valid", 64'({px_valid, px_x}), 64'({1'b1, 5'd0}));
    wait_x(5'd4, 10);
    px_ready = 1'b0;
    repeat (10) tick();
    check("bp x hold", 64'({px_valid, px_x}), 64'({1'b1, 5'd4}));
    check("bp data hold", 64'({px_rgb0, px_rgb1}), 64'({exp_rgb0(4, 6), 3'd7 - exp_rgb0(4, 6)}));
    for (int i = 0; i < COLS; i++) shift_pulse(i, 1, 1'b0, 3'd0);
    lat_pulse(3'd1);
    tick();
    check("drop err", 64'({err_short, err_overrun, err_drop}), 64'(3'b001));
    check("drop x hold", 64'(px_x), 64'd4);
    px_ready = 1'b1;
    repeat (COLS + 8) tick();
    check("drop pulses", 64'(n_drop - d0), 64'd1);
    check_beats("bp", 3'd4, 6, COLS);
    check("drop idle", 64'(px_valid), 64'd0);

    // Reset in the middle of a line, then a clean line afterwards.
    oe = 1'b0;
    repeat (20) tick();
    oe = 1'b1;
    for (int i = 0; i < COLS; i++) shift_pulse(i, 7, 1'b0, 3'd0);
    lat_pulse(3'd2);
    tick();
    check("rst pre on_cycles", 64'(on_cycles), 64'd20);
    wait_x(5'd10, 20);
    rst_n = 1'b0;
    #1;
    check("rst mid outputs", 64'({px_valid, px_x, px_row, px_rgb0, px_rgb1, px_last, on_cycles,
                                  err_short, err_overrun, err_drop}), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    run_line(post_rst);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hub75_receiver.md
# hub75_receiver

Receiving end of the HUB75 panel interface driven by `display_driver`. It samples the panel-side signals (`r0..b1`, `a0..a2`, `oe`, `lat`, `oclk`) in the system clock domain. It reconstructs each latched line into a per-column pixel stream with row address, and reports protocol errors and per-row on-time. It is used as a loopback monitor and panel model for bench and on-board checking of the driver.

## Interface
- `ROWS`, 8: addressed row pairs; row address width is clog2(ROWS).
- `COLUMNS`, 32: pixels per line, equal to the `oclk` pulses per line.
- `clk`  in  1: system clock, the same clock as `display_driver`.
- `rst_n`  in  1: asynchronous, active-low reset.
- `r0, g0, b0`  in  1 each: upper-half pixel bits.
- `r1, g1, b1`  in  1 each: lower-half pixel bits.
- `a0, a1, a2`  in  1 each: row address, with `a0` as LSB.
- `oe`  in  1: output enable, active-low (panel lit when 0).
- `lat`  in  1: latch strobe; its rising edge is the event.
- `oclk`  in  1: shift clock; its rising edge is the event.
- `px_valid`  out  1: pixel beat valid.
- `px_ready`  in  1: sink accepts the beat.
- `px_x`  out  clog2(COLUMNS): column index.
- `px_row`  out  clog2(ROWS): row address latched with this line.
- `px_rgb0`, `px_rgb1`  out  3: {r,g,b} for the upper and lower halves.
- `px_last`  out  1: high on the beat with `px_x == COLUMNS-1`.
- `on_cycles`  out  16: number of `oe==0` cycles between the two most recent `lat` rises.
- `err_short`, `err_overrun`, `err_drop`  out  1 each: single-cycle error pulses.

## Operation
- **Input sampling.** All inputs are registered once; `px_ready` is not registered.
  - Edge detection compares the registered value with its previous registered value.
  - `oclk` and `lat` must each be held at least 1 clk high and 1 clk low.
- **Shift.** On each `oclk` rise, {`r1,g1,b1`,`r0,g0,b0`} is written to `shbuf[COLUMNS-1-shcnt]`.
  - `shcnt` increments and saturates at COLUMNS.
  - A rise with `shcnt == COLUMNS` sets a sticky `ovf` flag and does not write.
  - The first bit shifted therefore lands at column COLUMNS-1.
- **Latch.** On each `lat` rise:
  - The address is sampled to `row_q`.
  - `on_cycles` takes the value of `oecnt`; `oecnt` is cleared.
  - `shcnt` and `ovf` are cleared.
  - The line is accepted only if `shcnt == COLUMNS`, `ovf == 0`, and the FSM is IDLE. An accepted line copies `shbuf` into `linebuf` and `row_q` into `px_row`, then goes to SEND.
  - If `ovf` is set: pulse `err_overrun`.
  - Else if `shcnt < COLUMNS`: pulse `err_short`.
  - Else if the FSM is in SEND: pulse `err_drop`.
  - Rejected lines produce no beats; only one error pulses per `lat` rise, in the priority above.
- **Oe counter.** `oecnt` increments every cycle the sampled `oe == 0` and saturates at 16'hFFFF.
- **FSM.**
  - IDLE: `px_valid = 0`.
  - SEND: `px_valid = 1`; `px_x` runs from 0 upward and advances on `px_valid && px_ready`.
  - The beat with `px_x == COLUMNS-1` accepted returns the FSM to IDLE.
- **Simultaneous `oclk` and `lat` rise in the same cycle.** The shift is applied first, so the latch decision uses the post-shift `shcnt`.
- **Continuous shifting.** `oclk` rises while `lat` is high are not blocked. They count toward the next line.
- **Reset.** All state clears asynchronously:
  - `shcnt = 0`, `oecnt = 0`, `ovf = 0`, FSM = IDLE.
  - All outputs are 0, including `on_cycles = 0`.
  - Reset mid-SEND abandons the line with no error pulse.

## Timing
- An input edge present before clk edge k is registered at k and detected at k+1. Its effect is visible after k+2.
- `lat` rise to first `px_valid`: high after edge k+2.
- `err_*` pulse: high for exactly one cycle, the same cycle `px_valid` would first have risen.
- `on_cycles`: updates in the same cycle as the error pulses.
- Throughput: one beat per cycle under `px_ready = 1`, so a line takes COLUMNS cycles.
- Beat outputs are stable while `px_valid && !px_ready`.

## Structure
- Shared package `hub75_pkg`:
  - rgb triple typedef;
  - COLUMNS/ROWS defaults;
  - error-code priority constants;
  - FSM state enum (IDLE, SEND).
- Sub-module `hub75_input_sampler`: registers the inputs and produces the `oclk_rise`/`lat_rise` strobes. It is shared with future panel monitors.
- `shbuf` and `linebuf` are flop arrays of COLUMNS x 6 bits.

## Test plan
- **Full line.** 32 `oclk` pulses where pulse i carries rgb0=i%8, rgb1=7-i%8; then `lat` with row 5 and `oe` low for 100 cycles beforehand.
  - Expect 32 beats with `px_row` = 5.
  - At `px_x` = x: rgb0 = (31-x)%8.
  - `px_last` high on x = 31.
  - `on_cycles` reads 100 after the following `lat`.
- **Short line.** 31 pulses then `lat` → one `err_short` pulse and no beats. The next full line streams normally.
- **Overrun.** 33 pulses then `lat` → one `err_overrun` pulse and no beats. `shcnt` is 0 afterwards.
- **Backpressure and drop.**
  - Hold `px_ready` low 10 cycles at x = 4 → `px_x` stays 4 and data stays stable.
  - A second full line with `lat` during SEND → `err_drop`, and the first line completes intact.
- **Simultaneous edges.** 32nd `oclk` rise in the same cycle as the `lat` rise → line accepted and column 0 holds the 32nd bit.
- **Reset mid-stream.** Assert `rst_n` = 0 at x = 10 → `px_valid` and all outputs are 0 immediately. A subsequent full line is received correctly.
